// File: rtl/nb_chk_pkg.sv
// ============================================================================
//  Module   : nb_chk_pkg
//  Purpose  : Shared types and constants for the dual-path lag checker.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package nb_chk_pkg;

    localparam int LAG_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    // Wide enough to hold any fill count up to LAG_MAX
    function automatic int fill_cnt_width();
        return $clog2(LAG_MAX + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nb_delay_line.sv
// ============================================================================
//  Module   : nb_delay_line
//  Purpose  : LAG-deep 1-bit shift register; q is d from LAG cycles ago.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module nb_delay_line #(
    parameter int LAG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [LAG-1:0] r_sr;

    generate
        if (LAG == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[LAG-2:0], d};
            end
        end
    endgenerate

    assign q = r_sr[LAG-1];

endmodule

`default_nettype wire

// File: rtl/nb_lag_checker.sv
// ============================================================================
//  Module   : nb_lag_checker
//  Purpose  : Aligns the fast stream to the slow stream, compares, counts
//             mismatches and raises a sticky fail flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module nb_lag_checker
    import nb_chk_pkg::*;
#(
    parameter int LAG       = 1,
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             fast_in,
    input  logic             slow_in,
    output logic             cmp_valid,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fail,
    output logic [1:0]       state
);

    localparam int               FILL_W      = fill_cnt_width();
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_err_limit = CNT_W'(ERR_LIMIT);
    localparam logic [FILL_W-1:0] c_fill_last = FILL_W'(LAG - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [FILL_W-1:0]   r_fill_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_fail;
    logic                r_cmp_valid;
    logic                r_match;

    logic                w_tap;
    logic                w_check_active;
    logic                w_fill_active;
    logic                w_fill_start;
    logic                w_mismatch;
    logic                w_fail_hit;
    logic [CNT_W-1:0]    w_cnt_inc;

    nb_delay_line #(.LAG(LAG)) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (fast_in),
        .q     (w_tap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // clr outranks en; any drop of en parks the FSM in IDLE
    always_comb begin
        w_next_state = r_state;
        if (clr || !en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_FILL;
                ST_FILL:  if (r_fill_cnt == c_fill_last) w_next_state = ST_CHECK;
                ST_CHECK: if (w_fail_hit) w_next_state = ST_FAIL;
                ST_FAIL:  w_next_state = ST_FAIL;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_check_active = (r_state == ST_CHECK) && en && !clr;
        w_fill_active  = (r_state == ST_FILL)  && en && !clr;
        w_fill_start   = (r_state == ST_IDLE)  && en && !clr;
        w_mismatch     = w_check_active && (w_tap != slow_in);
        w_cnt_inc      = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + CNT_W'(1);
        w_fail_hit     = w_mismatch && (w_cnt_inc == c_err_limit);
    end

    // Fill counter restarts whenever FILL is not continuing, so every re-entry waits LAG cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt  <= '0;
            r_cnt       <= '0;
            r_fail      <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            r_fill_cnt  <= w_fill_active ? r_fill_cnt + FILL_W'(1) : '0;
            r_cmp_valid <= w_check_active;
            if (w_check_active)
                r_match <= (w_tap == slow_in);
            if (clr || w_fill_start)
                r_cnt <= '0;
            else if (w_mismatch)
                r_cnt <= w_cnt_inc;
            if (clr)
                r_fail <= 1'b0;
            else if (w_fail_hit)
                r_fail <= 1'b1;
        end
    end

    assign cmp_valid    = r_cmp_valid;
    assign match        = r_match;
    assign mismatch_cnt = r_cnt;
    assign fail         = r_fail;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_nb_lag_checker.sv
// ============================================================================
//  Module   : tb_nb_lag_checker
//  Purpose  : Self-checking bench for nb_lag_checker (LAG=1 and LAG=3 builds).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nb_lag_checker;

    logic clk;
    logic rst_n;
    logic en;
    logic clr;
    logic fast_in;
    logic slow1;
    logic slow3;

    logic       cv1, m1, f1;
    logic [7:0] cnt1;
    logic [1:0] st1;
    logic       cv3, m3, f3;
    logic [1:0] cnt3;
    logic [1:0] st3;

    int checks = 0;
    int errors = 0;

    // Reference view of one checker instance
    typedef struct {
        int          st;
        int          fill;
        int          cnt;
        bit          fail;
        bit          valid;
        bit          match;
        logic [15:0] hist;
    } m_t;

    m_t ref1;
    m_t ref3;

    nb_lag_checker #(.LAG(1), .CNT_W(8), .ERR_LIMIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .fast_in(fast_in), .slow_in(slow1),
        .cmp_valid(cv1), .match(m1), .mismatch_cnt(cnt1), .fail(f1), .state(st1)
    );

    nb_lag_checker #(.LAG(3), .CNT_W(2), .ERR_LIMIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .fast_in(fast_in), .slow_in(slow3),
        .cmp_valid(cv3), .match(m3), .mismatch_cnt(cnt3), .fail(f3), .state(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic m_t model_reset();
        m_t m;
        m.st = 0; m.fill = 0; m.cnt = 0; m.fail = 0;
        m.valid = 0; m.match = 0; m.hist = '0;
        return m;
    endfunction

    // One clock edge of the behavioural model, from the checker's stated rules
    function automatic m_t model_step(m_t m, int lag, int cw, int lim,
                                      bit e, bit c, bit fst, bit slw);
        m_t n = m;
        int maxc = (1 << cw) - 1;
        bit tap = m.hist[lag-1];
        n.hist  = {m.hist[14:0], fst};
        n.valid = 0;
        if (c) begin
            n.st = 0; n.cnt = 0; n.fail = 0; n.fill = 0;
        end else if (!e) begin
            n.st = 0; n.fill = 0;
        end else begin
            case (m.st)
                0: begin n.st = 1; n.fill = 0; n.cnt = 0; end
                1: begin
                    if (m.fill + 1 == lag) begin n.st = 2; n.fill = 0; end
                    else n.fill = m.fill + 1;
                end
                2: begin
                    n.valid = 1;
                    n.match = (tap == slw);
                    if (tap != slw) begin
                        n.cnt = (m.cnt < maxc) ? m.cnt + 1 : maxc;
                        if (n.cnt == lim) begin n.fail = 1; n.st = 3; end
                    end
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("d1_state", int'(st1), ref1.st);
        check("d1_valid", int'(cv1), int'(ref1.valid));
        check("d1_cnt",   int'(cnt1), ref1.cnt);
        check("d1_fail",  int'(f1), int'(ref1.fail));
        if (ref1.valid) check("d1_match", int'(m1), int'(ref1.match));
        check("d3_state", int'(st3), ref3.st);
        check("d3_valid", int'(cv3), int'(ref3.valid));
        check("d3_cnt",   int'(cnt3), ref3.cnt);
        check("d3_fail",  int'(f3), int'(ref3.fail));
        if (ref3.valid) check("d3_match", int'(m3), int'(ref3.match));
    endtask

    // Drive one cycle: slow paths are the aligned fast history, optionally corrupted
    task automatic tick(input bit e, input bit c, input bit fst, input bit err1, input bit err3);
        en      = e;
        clr     = c;
        fast_in = fst;
        slow1   = ref1.hist[0] ^ err1;
        slow3   = ref3.hist[2] ^ err3;
        @(posedge clk);
        ref1 = model_step(ref1, 1, 8, 4, e, c, fst, slow1);
        ref3 = model_step(ref3, 3, 2, 3, e, c, fst, slow3);
        #1;
        compare_all();
    endtask

    initial begin
        bit [4:0] pat;
        pat = 5'b01101;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; fast_in = 1'b0; slow1 = 1'b0; slow3 = 1'b0;
        ref1 = model_reset();
        ref3 = model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(st1), 0);
        check("rst_valid", int'(cv1), 0);
        check("rst_match", int'(m1),  0);
        check("rst_cnt",   int'(cnt1), 0);
        check("rst_fail",  int'(f1),  0);
        check("rst_state3", int'(st3), 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        compare_all();

        // Aligned stream 1,0,1,1,0: all comparisons match
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, pat[i], 1'b0, 1'b0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("aligned_cnt", int'(cnt1), 0);
        check("aligned_state", int'(st1), 2);

        // Single corrupted slow sample
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("single_cnt",  int'(cnt1), 1);
        check("single_fail", int'(f1), 0);

        // Fresh run, then every slow sample inverted until FAIL
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clr_state3", int'(st3), 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("lag3_state", int'(st3), 2);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'(i), 1'b1, 1'b0);
        check("limit_cnt",   int'(cnt1), 4);
        check("limit_fail",  int'(f1), 1);
        check("limit_state", int'(st1), 3);

        // clr together with en while in FAIL
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clr_fail_state", int'(st1), 0);
        check("clr_fail_flag",  int'(f1), 0);
        check("clr_fail_cnt",   int'(cnt1), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_then_fill", int'(st1), 1);

        // Small-counter instance: mismatch then pause/resume, repeatedly
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b1);
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("pause_idle3", int'(st3), 0);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b1);
        check("sat_cnt3",  int'(cnt3), 3);
        check("sat_fail3", int'(f3), 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0, 1'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);

        // Asynchronous reset mid-CHECK, between edges
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
        check("pre_rst_state", int'(st1), 2);
        #2 rst_n = 1'b0;
        #1;
        ref1 = model_reset();
        ref3 = model_reset();
        check("arst_state", int'(st1), 0);
        check("arst_valid", int'(cv1), 0);
        check("arst_match", int'(m1), 0);
        check("arst_cnt",   int'(cnt1), 0);
        check("arst_fail",  int'(f1), 0);
        compare_all();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
